// File: rtl/serial_bit_driver_pkg.sv
// serial_bit_driver_pkg: shared state encoding, counter width helpers
// and parameter legality check for the serial bit driver.
package serial_bit_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2
    } state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int half);
        return (width >= 1) && (half >= 1);
    endfunction

endpackage

// File: rtl/serial_bit_driver_phase_timer.sv
// phase_timer: counts 0..HALF_PERIOD-1 and flags the last count of a
// strobe phase; clear holds it at zero.
module phase_timer
    import serial_bit_driver_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic terminal
);

    localparam int TW = cnt_w(HALF_PERIOD);
    localparam logic [TW-1:0] LAST = TW'(HALF_PERIOD - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign terminal = (count_q == LAST);

    // Advance the count, restarting at zero after the last count or on clear.
    always_comb begin
        count_d = count_q + TW'(1);
        if (clear || terminal) begin
            count_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_bit_driver.sv
// serial_bit_driver: shifts a handshaked word out as strobe/data pairs
// where data only moves while the strobe is low.
module serial_bit_driver
    import serial_bit_driver_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_sclk,
    output logic             io_sdata,
    output logic             io_busy,
    output logic             io_done
);

    localparam int BW = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    if (!params_ok(WIDTH, HALF_PERIOD)) begin : g_bad_params
        $error("serial_bit_driver: WIDTH and HALF_PERIOD must be >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shreg_shift;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             done_q, done_d;
    logic             phase_end;

    phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .terminal(phase_end)
    );

    assign io_in_ready = (state_q == IDLE);
    assign io_busy     = (state_q != IDLE);
    assign io_sclk     = sclk_q;
    assign io_sdata    = sdata_q;
    assign io_done     = done_q;

    // Next state, shift/count updates and the registered pin values.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        done_d      = 1'b0;
        shreg_shift = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        unique case (state_q)
            IDLE: begin
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                if (io_in_valid) begin
                    state_d   = SETUP;
                    shreg_d   = io_in_bits;
                    bit_cnt_d = '0;
                    sdata_d   = (MSB_FIRST != 0) ? io_in_bits[WIDTH-1]
                                                 : io_in_bits[0];
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                        sdata_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SETUP;
                        shreg_d   = shreg_shift;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        sdata_d   = (MSB_FIRST != 0) ? shreg_shift[WIDTH-1]
                                                     : shreg_shift[0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_driver.sv
// tb_serial_bit_driver: scoreboard bench over three driver configurations
// plus a rising-edge flip-flop receiver chain.
module tb_serial_bit_driver;

    localparam int NI = 3;
    localparam int WD [NI] = '{8, 8, 1};
    localparam int HP [NI] = '{2, 1, 3};
    localparam int MF [NI] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n = 3'b000;
    logic [2:0] valid = 3'b000;
    logic [2:0] ready, sclk, sdata, busy, done;
    logic [7:0] bits_a = 8'h00;
    logic [7:0] bits_b = 8'h00;
    logic [0:0] bits_c = 1'b0;

    serial_bit_driver #(.WIDTH(8), .HALF_PERIOD(2), .MSB_FIRST(1)) dut_a (
        .clock(clk), .reset(rst_n[0]), .io_in_valid(valid[0]),
        .io_in_ready(ready[0]), .io_in_bits(bits_a), .io_sclk(sclk[0]),
        .io_sdata(sdata[0]), .io_busy(busy[0]), .io_done(done[0])
    );

    serial_bit_driver #(.WIDTH(8), .HALF_PERIOD(1), .MSB_FIRST(0)) dut_b (
        .clock(clk), .reset(rst_n[1]), .io_in_valid(valid[1]),
        .io_in_ready(ready[1]), .io_in_bits(bits_b), .io_sclk(sclk[1]),
        .io_sdata(sdata[1]), .io_busy(busy[1]), .io_done(done[1])
    );

    serial_bit_driver #(.WIDTH(1), .HALF_PERIOD(3), .MSB_FIRST(1)) dut_c (
        .clock(clk), .reset(rst_n[2]), .io_in_valid(valid[2]),
        .io_in_ready(ready[2]), .io_in_bits(bits_c), .io_sclk(sclk[2]),
        .io_sdata(sdata[2]), .io_busy(busy[2]), .io_done(done[2])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic cur_bit [NI] = '{default: 1'b0};
    logic prev_sclk [NI] = '{default: 1'b0};
    bit exp_bit [NI][$];
    int exp_done [NI][$];

    // Flip-flop receiver chain fed by the first driver.
    logic [7:0] chain = 8'h00;
    always @(posedge sclk[0]) chain <= {chain[6:0], sdata[0]};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic set_bits(int k, logic [7:0] w);
        case (k)
            0: bits_a = w;
            1: bits_b = w;
            default: bits_c = w[0:0];
        endcase
    endtask

    task automatic push_exp(int k, logic [7:0] w, int t);
        for (int i = 0; i < WD[k]; i++)
            exp_bit[k].push_back(MF[k] != 0 ? w[WD[k]-1-i] : w[i]);
        exp_done[k].push_back(t + 2 * HP[k] * WD[k]);
    endtask

    // Called at a negedge with valid already high; returns cyc after the
    // accepting edge.
    task automatic accept(int k, output int t);
        int n = 0;
        while (!ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) check("accept_timeout", ready[k], 1);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    task automatic send(int k, logic [7:0] w, output int t);
        @(negedge clk);
        set_bits(k, w);
        valid[k] = 1'b1;
        accept(k, t);
        valid[k] = 1'b0;
        push_exp(k, w, t);
    endtask

    task automatic wait_idle(int k);
        int n = 0;
        while (exp_done[k].size() > 0 && n < 400) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("wait_idle", exp_done[k].size(), 0);
    endtask

    // Scoreboard monitor: bits at strobe rises, hold while high,
    // done timing, ready/busy while a word is in flight, idle pins.
    always @(posedge clk) begin
        int d;
        #2;
        for (int k = 0; k < NI; k++) begin
            if (sclk[k] && !prev_sclk[k]) begin
                if (exp_bit[k].size() > 0) begin
                    cur_bit[k] = exp_bit[k].pop_front();
                    check($sformatf("bit%0d", k), sdata[k], cur_bit[k]);
                end else begin
                    check($sformatf("spurious_rise%0d", k), sclk[k], 0);
                end
            end else if (sclk[k] && prev_sclk[k]) begin
                check($sformatf("hold_high%0d", k), sdata[k], cur_bit[k]);
            end
            if (exp_done[k].size() > 0 && cyc < exp_done[k][0]) begin
                check($sformatf("ready_busy%0d", k), ready[k], 0);
                check($sformatf("busy%0d", k), busy[k], 1);
            end
            if (done[k]) begin
                if (exp_done[k].size() > 0) begin
                    d = exp_done[k].pop_front();
                    check($sformatf("done_cycle%0d", k), cyc, d);
                end else begin
                    check($sformatf("spurious_done%0d", k), done[k], 0);
                end
            end else if (exp_done[k].size() > 0 && cyc > exp_done[k][0]) begin
                check($sformatf("done_missing%0d", k), done[k], 1);
                void'(exp_done[k].pop_front());
            end
            if (ready[k]) begin
                check($sformatf("idle_sclk%0d", k), sclk[k], 0);
                check($sformatf("idle_sdata%0d", k), sdata[k], 0);
            end
            prev_sclk[k] = sclk[k];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t1, t2, n, hi;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sclk", sclk[0], 0);
        check("rst_sdata", sdata[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_ready", ready[0], 1);
        check("rst_done", done[0], 0);
        @(negedge clk);
        rst_n = 3'b111;
        repeat (2) @(posedge clk);

        // Basic MSB-first word.
        send(0, 8'hA5, t);
        wait_idle(0);

        // LSB-first, one-cycle phases.
        send(1, 8'h01, t);
        wait_idle(1);

        // Back-to-back words with junk on io_in_bits while busy.
        @(negedge clk);
        bits_a = 8'h3C;
        valid[0] = 1'b1;
        accept(0, t1);
        push_exp(0, 8'h3C, t1);
        n = 0;
        @(negedge clk);
        while (!ready[0] && n < 200) begin
            bits_a = 8'($urandom);
            @(negedge clk);
            n++;
        end
        bits_a = 8'hC3;
        @(posedge clk);
        #1;
        t2 = cyc;
        valid[0] = 1'b0;
        push_exp(0, 8'hC3, t2);
        check("b2b_accept", t2, t1 + 33);
        wait_idle(0);
        repeat (2) @(posedge clk);

        // Reset during bit 3's high phase.
        send(0, 8'h5A, t);
        n = 0;
        @(negedge clk);
        while (cyc != t + 14 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_high", sclk[0], 1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        exp_bit[0].delete();
        exp_done[0].delete();
        check("midrst_sclk", sclk[0], 0);
        check("midrst_sdata", sdata[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_ready", ready[0], 1);
        check("midrst_done", done[0], 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (5) @(posedge clk);
        send(0, 8'hFF, t);
        wait_idle(0);

        // End-to-end through the flip-flop chain.
        send(0, 8'h96, t);
        wait_idle(0);
        check("ff_chain", chain, 8'h96);

        // Single-bit word with three-cycle phases.
        send(2, 8'h01, t);
        hi = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (sclk[2]) hi++;
        end
        check("w1_high_len", hi, 3);
        wait_idle(2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bit_driver.md
Name: serial_bit_driver

Overview:
- Transmit side of the edge-sampled serial link: takes a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time.
- Drives a generated strobe (io_sclk) and data (io_sdata) suitable for a flip-flop capturing on the strobe's rising edge.
- io_sdata changes only while io_sclk is low and is stable for the whole high phase, so any rising-edge D flip-flop or shift chain receives it cleanly.
- Sits between a word producer and the flip-flop-based receiver chain.

Parameters:
- WIDTH, 8, bits per word; must be >= 1.
- HALF_PERIOD, 2, system clock cycles per io_sclk low phase and per high phase; must be >= 1.
- MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- io_in_valid  input  1  producer has a word on io_in_bits.
- io_in_ready  output  1  block can accept a word; equals (state == IDLE).
- io_in_bits  input  WIDTH  word to transmit; sampled only on acceptance.
- io_sclk  output  1  generated strobe, registered.
- io_sdata  output  1  serial data, registered.
- io_busy  output  1  high in SETUP and HIGH states.
- io_done  output  1  one-cycle pulse after the last bit's high phase ends.

Behaviour:
- Reset (reset==0 at a clock edge) takes effect on that edge, even mid-word:
  - state=IDLE, io_sclk=0, io_sdata=0, io_done=0, io_busy=0, io_in_ready=1.
  - Shift register, bit counter and phase timer are cleared.
  - Any partially sent word is abandoned.
- States are IDLE, SETUP and HIGH.
- IDLE:
  - io_sclk=0, io_sdata=0.
  - Acceptance happens when io_in_valid && io_in_ready at edge t.
  - On acceptance, io_in_bits is loaded into the shift register, bit counter=0, timer=0, next state is SETUP.
  - In cycle t+1, io_sdata already equals the first bit.
- SETUP:
  - io_sclk=0; io_sdata holds the current bit.
  - Lasts exactly HALF_PERIOD cycles, then HIGH with timer=0.
- HIGH:
  - io_sclk=1; io_sdata unchanged.
  - Lasts exactly HALF_PERIOD cycles.
  - At its end, if bit counter == WIDTH-1: next state is IDLE and io_done=1 for that first IDLE cycle only.
  - Otherwise: shift, bit counter+1, next state is SETUP, and io_sdata presents the next bit in the same cycle io_sclk falls.
- Timing, with acceptance at edge t and H=HALF_PERIOD:
  - Bit i is driven from cycle t+1+2iH.
  - io_sclk rises at the start of cycle t+1+2iH+H.
  - Idle with io_done=1 at cycle t+1+2HW, where W=WIDTH.
  - Word latency is 2HW cycles.
- io_in_ready=0 while busy. io_in_valid and io_in_bits are ignored while busy; no buffering.
- Back-to-back words: a word accepted in the io_done cycle is legal. The next SETUP starts the following cycle, giving exactly one idle cycle with io_sclk=0 and io_sdata=0 between words.
- Widths:
  - Bit counter is clog2(WIDTH) bits, minimum 1.
  - Phase timer is clog2(HALF_PERIOD) bits, minimum 1.
  - Terminal compare is against HALF_PERIOD-1; no wrap-around beyond it.
- HALF_PERIOD=1: io_sclk toggles every cycle and io_sdata still changes only on the falling transitions.
- WIDTH=1: exactly one SETUP/HIGH pair.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, SETUP=1, HIGH=2);
  - the derived width constants for the counters;
  - the parameter legality checks.
- One sub-module, phase_timer:
  - counts 0..HALF_PERIOD-1 with a clear input;
  - asserts a terminal flag on the last count.
- FSM, shift register, bit counter and output registers stay in serial_bit_driver.

Test Plan:
- Basic MSB-first word:
  - Stimulus: WIDTH=8, H=2, MSB_FIRST=1, reset released, send 0xA5 accepted at edge t.
  - Response: bits sampled on io_sclk rising edges are 1,0,1,0,0,1,0,1. io_sclk rises at cycles t+3, t+7, ..., t+31. io_done=1 only in cycle t+33. io_in_ready=0 for cycles t+1..t+32.
- LSB-first, minimum half period:
  - Stimulus: MSB_FIRST=0, H=1, send 0x01.
  - Response: first sampled bit is 1, the remaining seven are 0, io_done at t+17.
  - Checker asserts io_sdata never changes while io_sclk==1.
- Back-to-back and ignored input:
  - Stimulus: present 0x3C then 0xC3 with io_in_valid held high, toggling io_in_bits mid-word.
  - Response: second word accepted exactly in the first word's io_done cycle. Received bytes are exactly 0x3C, 0xC3; mid-word changes to io_in_bits have no effect.
- Reset mid-word:
  - Stimulus: drive reset=0 for one edge during bit 3's HIGH phase.
  - Response: next cycle io_sclk=0, io_sdata=0, io_busy=0, io_in_ready=1, no io_done pulse. A fresh 0xFF afterwards transmits eight 1s.
- End-to-end with the flip-flop receiver:
  - Stimulus: drive a rising-edge D flip-flop chain of length 8 from io_sclk/io_sdata, send 0x96.
  - Response: the chain holds 0x96 after the 8th rising edge.
- WIDTH=1 boundary:
  - Stimulus: WIDTH=1, H=3, send 1.
  - Response: one io_sclk high pulse of 3 cycles, io_done at t+7.
